// File: rtl/useq.sv
// Microcode sequencer: runs the T-state counter, selects hardwired fetch steps or
// microcode ROM words, and tracks retired instructions and halt.
module useq #(
    parameter logic [15:0] FETCH0   = 16'h4800,
    parameter logic [15:0] FETCH1   = 16'h2A00,
    parameter int          RT_BIT   = 15,
    parameter int          HALT_BIT = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir_value,
    input  logic [15:0] rom_data,
    input  logic        stall,
    output logic [10:0] rom_addr,
    output logic [15:0] uinstr,
    output logic [2:0]  tstate,
    output logic        fetch,
    output logic        halted,
    output logic [15:0] icount
);

    logic [2:0]  tstate_r;
    logic        halted_r;
    logic [15:0] icount_r;

    logic [15:0] uinstr_s;
    logic        step_s;
    logic        rt_s;
    logic        halt_s;
    logic [2:0]  tstate_n_s;
    logic        halted_n_s;
    logic [15:0] icount_n_s;

    // Active microinstruction: T0/T1 are hardwired fetch steps, later steps come from ROM
    always_comb begin
        uinstr_s = rom_data;
        case (tstate_r)
            3'd0:    uinstr_s = FETCH0;
            3'd1:    uinstr_s = FETCH1;
            default: uinstr_s = rom_data;
        endcase
    end

    // RT/HALT only mean something once the opcode is loaded (T2 onward)
    assign step_s = (tstate_r >= 3'd2);
    assign rt_s   = step_s & uinstr_s[RT_BIT];
    assign halt_s = step_s & uinstr_s[HALT_BIT];

    // Next-state priority: halted, stall, HALT, RT, T7 wrap, advance
    always_comb begin
        tstate_n_s = tstate_r;
        halted_n_s = halted_r;
        icount_n_s = icount_r;
        if (halted_r || stall) begin
            tstate_n_s = tstate_r;
            halted_n_s = halted_r;
            icount_n_s = icount_r;
        end else if (halt_s) begin
            halted_n_s = 1'b1;
        end else if (rt_s || (tstate_r == 3'd7)) begin
            tstate_n_s = 3'd0;
            icount_n_s = icount_r + 16'd1;
        end else begin
            tstate_n_s = tstate_r + 3'd1;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tstate_r <= 3'd0;
            halted_r <= 1'b0;
            icount_r <= 16'd0;
        end else begin
            tstate_r <= tstate_n_s;
            halted_r <= halted_n_s;
            icount_r <= icount_n_s;
        end
    end

    assign rom_addr = {ir_value[15:8], tstate_r};
    assign uinstr   = uinstr_s;
    assign tstate   = tstate_r;
    assign fetch    = (tstate_r < 3'd2);
    assign halted   = halted_r;
    assign icount   = icount_r;

endmodule

// File: tb/tb_useq.sv
// Scoreboard bench for useq: the driver pushes expected outputs per cycle and a
// negedge monitor pops and compares them against the DUT.
module tb_useq;

    localparam logic [15:0] F0 = 16'h4800;
    localparam logic [15:0] F1 = 16'h2A00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir_value = 16'd0;
    logic [15:0] rom_data = 16'd0;
    logic        stall = 1'b0;
    logic [10:0] rom_addr;
    logic [15:0] uinstr;
    logic [2:0]  tstate;
    logic        fetch;
    logic        halted;
    logic [15:0] icount;

    int tests = 0;
    int fails = 0;
    int tag   = 0;

    typedef struct packed {
        logic [31:0] id;
        logic [2:0]  ts;
        logic [15:0] ui;
        logic [10:0] ra;
        logic        fe;
        logic        h;
        logic [15:0] ic;
    } exp_t;

    exp_t q[$];

    logic [2:0]  ts_m = 3'd0;
    logic        h_m  = 1'b0;
    logic [15:0] ic_m = 16'd0;

    useq dut (
        .clk(clk), .reset(reset), .ir_value(ir_value), .rom_data(rom_data),
        .stall(stall), .rom_addr(rom_addr), .uinstr(uinstr), .tstate(tstate),
        .fetch(fetch), .halted(halted), .icount(icount)
    );

    always #5 clk = ~clk;

    // Monitor: compare every queued expectation at the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if (tstate !== e.ts || uinstr !== e.ui || rom_addr !== e.ra ||
                fetch !== e.fe || halted !== e.h || icount !== e.ic) begin
                fails++;
                $display("FAIL cyc%0d: got ts=%0d ui=%h ra=%h fe=%b h=%b ic=%h, need ts=%0d ui=%h ra=%h fe=%b h=%b ic=%h",
                         e.id, tstate, uinstr, rom_addr, fetch, halted, icount,
                         e.ts, e.ui, e.ra, e.fe, e.h, e.ic);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, need %h", name, act, req);
        end
    endtask

    // One clock: drive inputs, queue expected outputs for this cycle, advance the model
    task automatic cyc(input logic st, input logic [15:0] rd, input logic [15:0] ir);
        exp_t e;
        stall    = st;
        rom_data = rd;
        ir_value = ir;
        e.id = tag;
        e.ts = ts_m;
        e.ui = (ts_m == 3'd0) ? F0 : ((ts_m == 3'd1) ? F1 : rd);
        e.ra = {ir[15:8], ts_m};
        e.fe = (ts_m < 3'd2);
        e.h  = h_m;
        e.ic = ic_m;
        q.push_back(e);
        tag++;
        @(posedge clk);
        #1;
        if (h_m || st) begin
            ts_m = ts_m;
        end else if (ts_m >= 3'd2 && e.ui[14]) begin
            h_m = 1'b1;
        end else if ((ts_m >= 3'd2 && e.ui[15]) || ts_m == 3'd7) begin
            ts_m = 3'd0;
            ic_m = ic_m + 16'd1;
        end else begin
            ts_m = ts_m + 3'd1;
        end
    endtask

    task automatic model_reset;
        ts_m = 3'd0;
        h_m  = 1'b0;
        ic_m = 16'd0;
    endtask

    initial begin
        ir_value = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tstate", {13'd0, tstate}, 16'd0);
        chk("rst_uinstr", uinstr, F0);
        chk("rst_fetch", {15'd0, fetch}, 16'd1);
        chk("rst_addr", {5'd0, rom_addr}, 16'h0090);
        reset = 1'b0;

        // Full 8-step instruction with no RT
        for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0000, 16'h1234);
        chk("wrap_tstate", {13'd0, tstate}, 16'd0);
        chk("wrap_icount", icount, 16'd1);

        // Three-cycle instructions ending on RT; bits set in T0/T1 are ignored
        for (int i = 0; i < 12; i++) cyc(1'b0, 16'h8000, 16'h0500);
        chk("rt_icount", icount, 16'd5);
        chk("rt_tstate", {13'd0, tstate}, 16'd0);

        // Stall at T2 holds a pending RT
        cyc(1'b0, 16'h8000, 16'h0500);
        cyc(1'b0, 16'h8000, 16'h0500);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h8000, 16'h0500);
        chk("stall_tstate", {13'd0, tstate}, 16'd2);
        chk("stall_icount", icount, 16'd5);
        cyc(1'b0, 16'h8000, 16'h0500);
        chk("unstall_tstate", {13'd0, tstate}, 16'd0);
        chk("unstall_icount", icount, 16'd6);

        // RT+HALT ignored in T0/T1, HALT wins at T2, then nothing moves
        cyc(1'b0, 16'hC000, 16'h0700);
        cyc(1'b0, 16'hC000, 16'h0700);
        chk("ign_tstate", {13'd0, tstate}, 16'd2);
        cyc(1'b0, 16'hC000, 16'h0700);
        chk("halt_flag", {15'd0, halted}, 16'd1);
        chk("halt_tstate", {13'd0, tstate}, 16'd2);
        chk("halt_icount", icount, 16'd6);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h8000, 16'h0700);
        chk("halt_hold", {12'd0, halted, tstate}, 16'd10);

        // Asynchronous reset mid-cycle, no clock edge needed
        #2;
        reset = 1'b1;
        #1;
        chk("areset_tstate", {13'd0, tstate}, 16'd0);
        chk("areset_halted", {15'd0, halted}, 16'd0);
        chk("areset_icount", icount, 16'd0);
        chk("areset_uinstr", uinstr, F0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Preload icount to FFFF while stalled at T2, then retire one more
        cyc(1'b0, 16'h8000, 16'h0300);
        cyc(1'b0, 16'h8000, 16'h0300);
        force dut.icount_r = 16'hFFFF;
        ic_m = 16'hFFFF;
        cyc(1'b1, 16'h8000, 16'h0300);
        release dut.icount_r;
        cyc(1'b1, 16'h8000, 16'h0300);
        chk("pre_icount", icount, 16'hFFFF);
        cyc(1'b0, 16'h8000, 16'h0300);
        chk("ovf_icount", icount, 16'h0000);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h8000, 16'h0300);
        chk("post_icount", icount, 16'h0001);

        @(negedge clk);
        #1;
        chk("queue_drained", q.size()[15:0], 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
